fhg_tx_pkt_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single 1024-bit CASPER TX AXIS input of the 400G AXIS adapter between N_PORTS independent CASPER AXIS producers.
- Grants one whole packet at a time; never interleaves beats of different ports.
- Holds off new grants while the DCMAC TX FIFO reports almost-full.
- Truncates and flags packets longer than MAX_BEATS.
- Sits directly upstream of the adapter's casper_tx_* port, in the adapter clock domain.

---
 rtl/fhg_pkg.sv | 16 +
 rtl/fhg_rr_pick.sv | 35 +++
 rtl/fhg_tx_pkt_arbiter.sv | 171 +++++++++++++++++
 tb/tb_fhg_tx_pkt_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fhg_pkg.sv
// Shared constants and FSM state type for the FHG 400G TX packet arbiter.
// Beat geometry is derived from the 8192-byte maximum packet on a 1024-bit bus.
package fhg_pkg;

  localparam int FHG_PKT_BYTES  = 8192;
  localparam int FHG_DATA_WIDTH = 1024;
  localparam int FHG_KEEP_WIDTH = FHG_DATA_WIDTH / 8;
  localparam int FHG_MAX_BEATS  = FHG_PKT_BYTES / FHG_KEEP_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } fhg_state_t;

endpackage

// File: rtl/fhg_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, searching circularly.
// Implemented as rotate, priority-encode, un-rotate.
module fhg_rr_pick #(
  parameter int N_PORTS = 4,
  parameter int ID_W    = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  localparam logic [ID_W:0] NP = (ID_W + 1)'(N_PORTS);

  logic [N_PORTS-1:0] w_rot;
  logic [ID_W-1:0]    w_enc;
  logic [ID_W:0]      w_sum;

  // Bit 0 of the rotated vector corresponds to port rr_ptr
  assign w_rot     = N_PORTS'({req, req} >> rr_ptr);
  assign gnt_valid = |req;

  always_comb begin
    w_enc = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_enc = ID_W'(i);
      end
    end
  end

  assign w_sum  = {1'b0, rr_ptr} + {1'b0, w_enc};
  assign gnt_id = (w_sum >= NP) ? ID_W'(w_sum - NP) : w_sum[ID_W-1:0];

endmodule

// File: rtl/fhg_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding the 400G adapter's CASPER TX AXIS port.
// Whole packets only; grants held off on DCMAC almost-full; oversize packets truncated and drained.
module fhg_tx_pkt_arbiter
  import fhg_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = FHG_DATA_WIDTH,
  parameter int KEEP_WIDTH = FHG_KEEP_WIDTH,
  parameter int MAX_BEATS  = FHG_MAX_BEATS,
  parameter int ID_W       = $clog2(N_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [N_PORTS*KEEP_WIDTH-1:0] s_tkeep,
  input  logic [N_PORTS-1:0]            s_tvalid,
  input  logic [N_PORTS-1:0]            s_tlast,
  input  logic [N_PORTS-1:0]            s_tuser,
  output logic [N_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic [KEEP_WIDTH-1:0]         m_tkeep,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  output logic                          m_tuser,
  input  logic                          m_tready,
  input  logic                          tx_af,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic [31:0]                   pkt_cnt,
  output logic [15:0]                   oversize_cnt
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  fhg_state_t        r_state;
  fhg_state_t        w_next_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_grant_id;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [31:0]       r_pkt_cnt;
  logic [15:0]       r_oversize_cnt;

  logic [DATA_WIDTH-1:0] w_data [N_PORTS];
  logic [KEEP_WIDTH-1:0] w_keep [N_PORTS];

  logic            w_gnt_valid;
  logic [ID_W-1:0] w_gnt_id;
  logic [ID_W-1:0] w_rr_next;
  logic            w_g_valid;
  logic            w_g_last;
  logic            w_g_user;
  logic            w_last_beat;
  logic            w_grant;
  logic            w_xfer;
  logic            w_pkt_done;
  logic            w_oversize;
  logic            w_release;

  for (genvar k = 0; k < N_PORTS; k++) begin : g_unpack
    assign w_data[k] = s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
    assign w_keep[k] = s_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH];
  end

  fhg_rr_pick #(
    .N_PORTS (N_PORTS),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req       (s_tvalid),
    .rr_ptr    (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  assign w_g_valid   = s_tvalid[r_grant_id];
  assign w_g_last    = s_tlast[r_grant_id];
  assign w_g_user    = s_tuser[r_grant_id];
  assign m_tdata     = w_data[r_grant_id];
  assign m_tkeep     = w_keep[r_grant_id];
  assign w_last_beat = (r_beat_cnt == BEAT_W'(MAX_BEATS - 1));
  assign w_rr_next   = (r_grant_id == ID_W'(N_PORTS - 1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The granted port is wired straight through in XFER, so handshakes add no latency
  always_comb begin
    w_next_state = r_state;
    s_tready     = '0;
    m_tvalid     = 1'b0;
    m_tlast      = 1'b0;
    m_tuser      = 1'b0;
    w_grant      = 1'b0;
    w_xfer       = 1'b0;
    w_pkt_done   = 1'b0;
    w_oversize   = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!tx_af && w_gnt_valid) begin
          w_grant      = 1'b1;
          w_next_state = XFER;
        end
      end
      XFER: begin
        s_tready[r_grant_id] = m_tready;
        m_tvalid             = w_g_valid;
        m_tlast              = w_g_last | w_last_beat;
        m_tuser              = w_g_user | (w_last_beat & ~w_g_last);
        w_xfer               = w_g_valid & m_tready;
        if (w_xfer) begin
          if (w_g_last) begin
            w_pkt_done   = 1'b1;
            w_release    = 1'b1;
            w_next_state = IDLE;
          end else if (w_last_beat) begin
            w_pkt_done   = 1'b1;
            w_oversize   = 1'b1;
            w_next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        s_tready[r_grant_id] = 1'b1;
        if (w_g_valid && w_g_last) begin
          w_release    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr       <= '0;
      r_grant_id     <= '0;
      r_beat_cnt     <= '0;
      r_pkt_cnt      <= '0;
      r_oversize_cnt <= '0;
    end else begin
      if (w_grant) begin
        r_grant_id <= w_gnt_id;
        r_beat_cnt <= '0;
      end else if (w_xfer) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_release) begin
        r_rr_ptr <= w_rr_next;
      end
      if (w_pkt_done) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
      if (w_oversize && (r_oversize_cnt != 16'hFFFF)) begin
        r_oversize_cnt <= r_oversize_cnt + 16'd1;
      end
    end
  end

  assign grant_id     = r_grant_id;
  assign busy         = (r_state != IDLE);
  assign pkt_cnt      = r_pkt_cnt;
  assign oversize_cnt = r_oversize_cnt;

endmodule

// File: tb/tb_fhg_tx_pkt_arbiter.sv
// Directed bench for fhg_tx_pkt_arbiter: per-port AXIS producers with payload {port, word seq}
// in the low 32 data bits; output beats are logged and compared with hand-derived sequences.
module tb_fhg_tx_pkt_arbiter;
  import fhg_pkg::*;

  localparam int NP = 4;
  localparam int DW = FHG_DATA_WIDTH;
  localparam int KW = FHG_KEEP_WIDTH;
  localparam int MB = FHG_MAX_BEATS;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NP*DW-1:0] s_tdata;
  logic [NP*KW-1:0] s_tkeep;
  logic [NP-1:0]    s_tvalid;
  logic [NP-1:0]    s_tlast;
  logic [NP-1:0]    s_tuser;
  logic [NP-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tuser;
  logic             m_tready;
  logic             tx_af;
  logic [IW-1:0]    grant_id;
  logic             busy;
  logic [31:0]      pkt_cnt;
  logic [15:0]      oversize_cnt;

  fhg_tx_pkt_arbiter #(
    .N_PORTS    (NP),
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .MAX_BEATS  (MB),
    .ID_W       (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tdata      (s_tdata),
    .s_tkeep      (s_tkeep),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tuser      (s_tuser),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tkeep      (m_tkeep),
    .m_tvalid     (m_tvalid),
    .m_tlast      (m_tlast),
    .m_tuser      (m_tuser),
    .m_tready     (m_tready),
    .tx_af        (tx_af),
    .grant_id     (grant_id),
    .busy         (busy),
    .pkt_cnt      (pkt_cnt),
    .oversize_cnt (oversize_cnt)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  int srcLen  [NP];
  int srcBeat [NP];
  int srcPkts [NP];
  int srcSeq  [NP];

  logic [31:0] logWord [$];
  bit          logLast [$];
  bit          logUser [$];
  int          logCyc  [$];
  int          cycleNum;
  int          discardCnt;
  int          mirrorErr;
  int          keepErr;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] wordAt(input int i);
    return (i < logWord.size()) ? logWord[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [1:0] flagsAt(input int i);
    return (i < logWord.size()) ? {logLast[i], logUser[i]} : 2'bxx;
  endfunction

  function automatic logic [31:0] expWord(input int port, input int seq);
    return {8'(port), 24'(seq)};
  endfunction

  function automatic bit anyPending();
    bit p = 1'b0;
    for (int k = 0; k < NP; k++) begin
      if (srcPkts[k] > 0) p = 1'b1;
    end
    return p;
  endfunction

  task automatic driveInputs();
    for (int k = 0; k < NP; k++) begin
      s_tvalid[k]           = (srcPkts[k] > 0);
      s_tlast[k]            = (srcBeat[k] == srcLen[k] - 1);
      s_tuser[k]            = 1'b0;
      s_tkeep[k*KW +: KW]   = '1;
      s_tdata[k*DW +: DW]   = DW'(expWord(k, srcSeq[k]));
    end
  endtask

  task automatic applyStimulus(input int port, input int len, input int npkts);
    srcLen[port]  = len;
    srcBeat[port] = 0;
    srcPkts[port] = npkts;
    driveInputs();
  endtask

  task automatic clearSources();
    for (int k = 0; k < NP; k++) begin
      srcLen[k]  = 1;
      srcBeat[k] = 0;
      srcPkts[k] = 0;
      srcSeq[k]  = 0;
    end
    driveInputs();
  endtask

  task automatic clearLog();
    logWord.delete();
    logLast.delete();
    logUser.delete();
    logCyc.delete();
    cycleNum   = 0;
    discardCnt = 0;
    mirrorErr  = 0;
    keepErr    = 0;
  endtask

  // Sample at the falling edge, let the rising edge commit, then advance producers
  task automatic stepCycle();
    bit hs [NP];
    @(negedge clk);
    for (int k = 0; k < NP; k++) begin
      hs[k] = s_tvalid[k] && s_tready[k];
      if (hs[k] && !m_tvalid) discardCnt++;
    end
    if (busy && (s_tready[grant_id] !== m_tready)) mirrorErr++;
    if (m_tvalid && m_tready) begin
      logWord.push_back(m_tdata[31:0]);
      logLast.push_back(m_tlast);
      logUser.push_back(m_tuser);
      logCyc.push_back(cycleNum);
      if (m_tkeep !== '1) keepErr++;
    end
    @(posedge clk);
    cycleNum++;
    #1;
    for (int k = 0; k < NP; k++) begin
      if (hs[k]) begin
        srcSeq[k]++;
        if (srcBeat[k] == srcLen[k] - 1) begin
          srcBeat[k] = 0;
          srcPkts[k]--;
        end else begin
          srcBeat[k]++;
        end
      end
    end
    driveInputs();
  endtask

  task automatic runUntilDone(input string tag, input int maxCyc);
    int n = 0;
    bit timedOut;
    while ((anyPending() || busy) && (n < maxCyc)) begin
      stepCycle();
      n++;
    end
    timedOut = anyPending() || busy;
    checkOutput({tag, "_timeout"}, 64'(timedOut), 64'd0);
  endtask

  task automatic doReset();
    rst      = 1'b0;
    tx_af    = 1'b0;
    m_tready = 1'b1;
    clearSources();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    clearLog();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int dropCyc;
    int pat [4] = '{1, 0, 0, 1};

    // Reset state, with a request present to show nothing is granted under reset
    rst      = 1'b0;
    tx_af    = 1'b0;
    m_tready = 1'b1;
    clearSources();
    applyStimulus(0, 1, 1);
    #12;
    checkOutput("rst_s_tready", 64'(s_tready), 64'd0);
    checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    checkOutput("rst_oversize_cnt", 64'(oversize_cnt), 64'd0);
    checkOutput("rst_grant_id", 64'(grant_id), 64'd0);

    // Two 64-beat packets on ports 0 and 2, then check the round-robin pointer moved to 3
    doReset();
    applyStimulus(0, 64, 1);
    applyStimulus(2, 64, 1);
    runUntilDone("t1", 400);
    checkOutput("t1_beats", 64'(logWord.size()), 64'd128);
    for (int b = 0; b < 128; b++) begin
      checkOutput($sformatf("t1_beat%0d", b), {30'd0, flagsAt(b), wordAt(b)},
                  {30'd0, (b % 64) == 63, 1'b0, expWord((b < 64) ? 0 : 2, b % 64)});
    end
    checkOutput("t1_idle_gap", (logWord.size() >= 65) ? 64'(logCyc[64] - logCyc[63]) : 64'd0, 64'd2);
    checkOutput("t1_pkt_cnt", 64'(pkt_cnt), 64'd2);
    checkOutput("t1_keep", 64'(keepErr), 64'd0);
    applyStimulus(0, 1, 1);
    applyStimulus(3, 1, 1);
    runUntilDone("t1b", 50);
    checkOutput("t1_next_port3", 64'(wordAt(128)), 64'(expWord(3, 0)));
    checkOutput("t1_then_port0", 64'(wordAt(129)), 64'(expWord(0, 64)));

    // All four ports, three 3-beat packets each: strict 0,1,2,3 rotation with no interleave
    doReset();
    for (int k = 0; k < NP; k++) applyStimulus(k, 3, 3);
    runUntilDone("t2", 400);
    checkOutput("t2_beats", 64'(logWord.size()), 64'd36);
    for (int b = 0; b < 36; b++) begin
      checkOutput($sformatf("t2_beat%0d", b), {30'd0, flagsAt(b), wordAt(b)},
                  {30'd0, (b % 3) == 2, 1'b0, expWord((b / 3) % 4, (b / 12) * 3 + b % 3)});
    end
    checkOutput("t2_pkt_cnt", 64'(pkt_cnt), 64'd12);

    // Almost-full mid-packet: packet finishes, no new grant while held, regrant one cycle after release
    doReset();
    applyStimulus(1, 64, 1);
    applyStimulus(2, 2, 1);
    n = 0;
    while (logWord.size() < 10 && n < 100) begin stepCycle(); n++; end
    tx_af = 1'b1;
    n = 0;
    while ((srcPkts[1] > 0 || busy) && n < 200) begin stepCycle(); n++; end
    repeat (5) stepCycle();
    checkOutput("t3_beats_held", 64'(logWord.size()), 64'd64);
    checkOutput("t3_last_beat", {30'd0, flagsAt(63), wordAt(63)}, {30'd0, 2'b10, expWord(1, 63)});
    checkOutput("t3_busy_held", 64'(busy), 64'd0);
    checkOutput("t3_port2_waiting", 64'(s_tvalid[2]), 64'd1);
    dropCyc = cycleNum;
    tx_af = 1'b0;
    n = 0;
    while (logWord.size() < 65 && n < 20) begin stepCycle(); n++; end
    checkOutput("t3_regrant_delay", (logWord.size() >= 65) ? 64'(logCyc[64] - dropCyc) : 64'hFF, 64'd1);
    checkOutput("t3_regrant_port", 64'(wordAt(64)), 64'(expWord(2, 0)));
    runUntilDone("t3", 50);
    checkOutput("t3_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // 70-beat packet on port 3: truncated at 64 with error flag, remaining 6 beats drained
    doReset();
    applyStimulus(3, 70, 1);
    runUntilDone("t4", 300);
    checkOutput("t4_beats", 64'(logWord.size()), 64'd64);
    checkOutput("t4_beat63", {30'd0, flagsAt(62), wordAt(62)}, {30'd0, 2'b00, expWord(3, 62)});
    checkOutput("t4_beat64", {30'd0, flagsAt(63), wordAt(63)}, {30'd0, 2'b11, expWord(3, 63)});
    checkOutput("t4_drained", 64'(discardCnt), 64'd6);
    checkOutput("t4_src_consumed", 64'(srcSeq[3]), 64'd70);
    checkOutput("t4_oversize_cnt", 64'(oversize_cnt), 64'd1);
    checkOutput("t4_pkt_cnt", 64'(pkt_cnt), 64'd1);
    checkOutput("t4_busy", 64'(busy), 64'd0);

    // Backpressure pattern 1,0,0,1 on an 8-beat port-0 packet
    doReset();
    applyStimulus(0, 8, 1);
    n = 0;
    while ((anyPending() || busy) && n < 100) begin
      m_tready = pat[n % 4][0];
      stepCycle();
      n++;
    end
    m_tready = 1'b1;
    checkOutput("t5_done", 64'(anyPending() || busy), 64'd0);
    checkOutput("t5_beats", 64'(logWord.size()), 64'd8);
    for (int b = 0; b < 8; b++) begin
      checkOutput($sformatf("t5_beat%0d", b), {30'd0, flagsAt(b), wordAt(b)},
                  {30'd0, b == 7, 1'b0, expWord(0, b)});
    end
    checkOutput("t5_tready_mirror", 64'(mirrorErr), 64'd0);
    checkOutput("t5_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Asynchronous reset at beat 20; afterwards counters cleared and port 0 wins first
    doReset();
    applyStimulus(2, 1, 1);
    runUntilDone("t6a", 20);
    checkOutput("t6_pre_pkt_cnt", 64'(pkt_cnt), 64'd1);
    applyStimulus(0, 64, 1);
    n = 0;
    while (logWord.size() < 21 && n < 100) begin stepCycle(); n++; end
    #2;
    checkOutput("t6_busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    checkOutput("t6_async_s_tready", 64'(s_tready), 64'd0);
    checkOutput("t6_async_m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("t6_async_busy", 64'(busy), 64'd0);
    clearSources();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    clearLog();
    checkOutput("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
    checkOutput("t6_oversize_cnt", 64'(oversize_cnt), 64'd0);
    checkOutput("t6_grant_id", 64'(grant_id), 64'd0);
    applyStimulus(0, 2, 1);
    applyStimulus(3, 2, 1);
    runUntilDone("t6b", 50);
    checkOutput("t6_first_port0", 64'(wordAt(0)), 64'(expWord(0, 0)));
    checkOutput("t6_second_port3", 64'(wordAt(2)), 64'(expWord(3, 0)));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
